// File: rtl/clk_step_pkg.sv
// Shared definitions for the single-step clock controller.
// State encodings are exported for display and debug logic.
package clk_step_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BURST = 2'b10
    } state_t;

    localparam int unsigned BURST_W = 16;
    localparam int unsigned CNT_W   = 32;

    // A zero-length step still advances the pipeline by one cycle.
    function automatic logic [BURST_W-1:0] burst_load(
        input logic [BURST_W-1:0] len
    );
        return (len == '0) ? BURST_W'(1) : len;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debouncer, rising-edge pulse.
// A button held through reset must be released before it can pulse again.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clock,
    input  logic rst,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_lvl_d;
    logic          r_armed;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clock) begin
        r_s1 <= i_btn;
        r_s2 <= r_s1;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_level <= 1'b0;
            r_lvl_d <= 1'b0;
            r_armed <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_lvl_d <= r_level;
            if (!r_s2) begin
                r_armed <= 1'b1;
            end
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_pulse = r_level & ~r_lvl_d & r_armed;

endmodule

// File: rtl/clk_step_ctrl.sv
// Run / step / halt controller producing the pipeline clock-gate enable.
// Button commands arrive as single-cycle pulses from btn_debounce.
module clk_step_ctrl
    import clk_step_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 1000000,
    parameter int unsigned RUN_TIMEOUT = 500000000
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               btn_run,
    input  logic               btn_step,
    input  logic               btn_halt,
    input  logic [BURST_W-1:0] burst_len,
    output logic               cpu_clk_en,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic               timeout_flag
);

    localparam logic [31:0] TO_LAST = 32'(RUN_TIMEOUT - 1);

    logic w_run;
    logic w_step;
    logic w_halt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run (
        .clock   (clock),
        .rst     (rst),
        .i_btn   (btn_run),
        .o_pulse (w_run)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
        .clock   (clock),
        .rst     (rst),
        .i_btn   (btn_step),
        .o_pulse (w_step)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_halt (
        .clock   (clock),
        .rst     (rst),
        .i_btn   (btn_halt),
        .o_pulse (w_halt)
    );

    state_t             r_state;
    state_t             w_state_n;
    logic [BURST_W-1:0] r_rem;
    logic [BURST_W-1:0] w_rem_n;
    logic [31:0]        r_tcnt;
    logic [31:0]        w_tcnt_n;
    logic               r_flag;
    logic               w_flag_n;
    logic               r_en;
    logic [CNT_W-1:0]   r_cycle_cnt;

    always_comb begin
        w_state_n = r_state;
        w_rem_n   = r_rem;
        w_tcnt_n  = r_tcnt;
        w_flag_n  = r_flag;
        if ((w_run | w_step) & ~w_halt) begin
            w_flag_n = 1'b0;
        end
        unique case (r_state)
            ST_IDLE: begin
                if (w_halt) begin
                    w_state_n = ST_IDLE;
                end else if (w_run) begin
                    w_state_n = ST_RUN;
                    w_tcnt_n  = '0;
                end else if (w_step) begin
                    w_state_n = ST_BURST;
                    w_rem_n   = burst_load(burst_len);
                end
            end
            ST_RUN: begin
                w_tcnt_n = r_tcnt + 32'd1;
                if (w_halt) begin
                    w_state_n = ST_IDLE;
                end else if (r_tcnt == TO_LAST) begin
                    w_state_n = ST_IDLE;
                    w_flag_n  = 1'b1;
                end
            end
            ST_BURST: begin
                if (w_halt) begin
                    w_state_n = ST_IDLE;
                    w_rem_n   = '0;
                end else if (w_run) begin
                    w_state_n = ST_RUN;
                    w_tcnt_n  = '0;
                    w_rem_n   = '0;
                end else if (r_rem == BURST_W'(1)) begin
                    w_state_n = ST_IDLE;
                    w_rem_n   = '0;
                end else begin
                    w_rem_n = r_rem - BURST_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_rem_n   = '0;
            end
        endcase
    end

    // Enable is registered alongside state so it never lags the FSM.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_tcnt      <= '0;
            r_flag      <= 1'b0;
            r_en        <= 1'b0;
            r_cycle_cnt <= '0;
        end else begin
            r_state     <= w_state_n;
            r_rem       <= w_rem_n;
            r_tcnt      <= w_tcnt_n;
            r_flag      <= w_flag_n;
            r_en        <= (w_state_n != ST_IDLE);
            r_cycle_cnt <= r_cycle_cnt + {{(CNT_W-1){1'b0}}, r_en};
        end
    end

    assign cpu_clk_en   = r_en;
    assign state        = r_state;
    assign cycle_cnt    = r_cycle_cnt;
    assign timeout_flag = r_flag;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Directed and randomized bench for clk_step_ctrl against a behavioural model.
// Small debounce and timeout values keep scenarios short.
module tb_clk_step_ctrl;

    localparam int DEB = 4;
    localparam int TO  = 20;

    logic        clock = 1'b0;
    logic        rst;
    logic        btn_run;
    logic        btn_step;
    logic        btn_halt;
    logic [15:0] burst_len;
    logic        cpu_clk_en;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;
    logic        timeout_flag;

    clk_step_ctrl #(.DEB_CYCLES(DEB), .RUN_TIMEOUT(TO)) dut (
        .clock        (clock),
        .rst          (rst),
        .btn_run      (btn_run),
        .btn_step     (btn_step),
        .btn_halt     (btn_halt),
        .burst_len    (burst_len),
        .cpu_clk_en   (cpu_clk_en),
        .state        (state),
        .cycle_cnt    (cycle_cnt),
        .timeout_flag (timeout_flag)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          m_state;
    bit          m_en;
    logic [31:0] m_cnt;
    bit          m_flag;
    int          m_rem;
    int          m_tcnt;
    bit          rq1[3];
    bit          rq2[3];
    int          run_len[3];
    bit          last_s[3];
    bit          lvl[3];
    bit          arm[3];
    bit          pend[3];

    int en_cycles;
    int en_runs;
    bit prev_en;

    // Index 0 run, 1 step, 2 halt.
    task automatic model_edge();
        bit b[3];
        bit w[3];
        bit pr, ps, ph;
        b[0] = btn_run;
        b[1] = btn_step;
        b[2] = btn_halt;
        for (int i = 0; i < 3; i++) begin
            w[i]   = rq2[i];
            rq2[i] = rq1[i];
            rq1[i] = b[i];
        end
        if (rst) begin
            m_state = 0; m_en = 0; m_cnt = 0;
            m_flag = 0; m_rem = 0; m_tcnt = 0;
            for (int i = 0; i < 3; i++) begin
                run_len[i] = 0; lvl[i] = 0;
                arm[i] = 0; pend[i] = 0;
            end
            return;
        end
        pr = pend[0]; ps = pend[1]; ph = pend[2];
        if (m_en) m_cnt = m_cnt + 1;
        if ((pr || ps) && !ph) m_flag = 0;
        case (m_state)
            0: begin
                if (ph) ;
                else if (pr) begin m_state = 1; m_tcnt = 0; end
                else if (ps) begin
                    m_state = 2;
                    m_rem = (burst_len == 0) ? 1 : int'(burst_len);
                end
            end
            1: begin
                m_tcnt++;
                if (ph) m_state = 0;
                else if (m_tcnt == TO) begin m_state = 0; m_flag = 1; end
            end
            default: begin
                if (ph) begin m_state = 0; m_rem = 0; end
                else if (pr) begin m_state = 1; m_tcnt = 0; m_rem = 0; end
                else begin
                    m_rem--;
                    if (m_rem == 0) m_state = 0;
                end
            end
        endcase
        m_en = (m_state != 0);
        for (int i = 0; i < 3; i++) begin
            bit rose;
            rose = 0;
            if (run_len[i] > 0 && w[i] == last_s[i]) run_len[i]++;
            else begin last_s[i] = w[i]; run_len[i] = 1; end
            if (!w[i]) arm[i] = 1;
            if (run_len[i] >= DEB && w[i] != lvl[i]) begin
                lvl[i] = w[i];
                rose = w[i];
            end
            pend[i] = rose && arm[i];
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        cyc++;
        checks++;
        if (state !== 2'(m_state) || cpu_clk_en !== m_en ||
            cycle_cnt !== m_cnt || timeout_flag !== m_flag) begin
            errors++;
            $display("FAIL cycle %0d outputs: got st=%0d en=%0d cnt=%h flag=%0d, want st=%0d en=%0d cnt=%h flag=%0d",
                     cyc, state, cpu_clk_en, cycle_cnt, timeout_flag,
                     m_state, m_en, m_cnt, m_flag);
        end
        if (cpu_clk_en === 1'b1) begin
            en_cycles++;
            if (!prev_en) en_runs++;
        end
        prev_en = (cpu_clk_en === 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic wait_state(input int s, input string nm);
        int n;
        n = 0;
        while (m_state != s && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (m_state != s) begin
            errors++;
            $display("FAIL %s: timed out, model state %0d, want %0d", nm, m_state, s);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);
    endtask

    task automatic clr_stats();
        en_cycles = 0;
        en_runs   = 0;
    endtask

    initial begin
        rst = 1'b1; btn_run = 0; btn_step = 0; btn_halt = 0;
        burst_len = 16'd3;
        m_state = 0; m_en = 0; m_cnt = 0; m_flag = 0;
        m_rem = 0; m_tcnt = 0; prev_en = 0;
        for (int i = 0; i < 3; i++) begin
            rq1[i] = 0; rq2[i] = 0; run_len[i] = 0;
            last_s[i] = 0; lvl[i] = 0; arm[i] = 0; pend[i] = 0;
        end
        do_reset();
        chk("reset_state", 32'(state), 0);
        chk("reset_en", 32'(cpu_clk_en), 0);
        chk("reset_cnt", cycle_cnt, 0);

        // Step burst of three.
        clr_stats();
        btn_step = 1; idle(8); btn_step = 0; idle(15);
        chk("burst3_en_cycles", en_cycles, 3);
        chk("burst3_contig", en_runs, 1);
        chk("burst3_cnt", cycle_cnt, 3);
        chk("burst3_state", 32'(state), 0);

        // Bouncing run press, then free-run to timeout.
        do_reset();
        clr_stats();
        btn_run = 1; idle(2); btn_run = 0; idle(2);
        btn_run = 1; idle(2); btn_run = 0; idle(2);
        btn_run = 1; idle(10); btn_run = 0; idle(30);
        chk("run_en_cycles", en_cycles, 20);
        chk("run_single_pulse", en_runs, 1);
        chk("run_timeout_flag", 32'(timeout_flag), 1);
        chk("run_cnt", cycle_cnt, 20);

        // Halt during run.
        btn_run = 1;
        wait_state(1, "enter_run");
        btn_run = 0; idle(2);
        btn_halt = 1;
        wait_state(0, "halt_run");
        chk("halt_en", 32'(cpu_clk_en), 0);
        chk("halt_flag", 32'(timeout_flag), 0);
        btn_halt = 0; idle(10);

        // Run and halt together, then zero-length step.
        clr_stats();
        btn_run = 1; btn_halt = 1; idle(8);
        btn_run = 0; btn_halt = 0; idle(10);
        chk("run_halt_en_cycles", en_cycles, 0);
        chk("run_halt_state", 32'(state), 0);
        clr_stats();
        burst_len = 16'd0;
        btn_step = 1; idle(8); btn_step = 0; idle(10);
        chk("burst0_en_cycles", en_cycles, 1);

        // Reset mid-burst with the step button still held.
        do_reset();
        burst_len = 16'd10;
        btn_step = 1;
        wait_state(2, "enter_burst");
        idle(4);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_state", 32'(state), 0);
        chk("midrst_en", 32'(cpu_clk_en), 0);
        chk("midrst_cnt", cycle_cnt, 0);
        clr_stats();
        idle(20);
        chk("held_no_burst", en_cycles, 0);
        btn_step = 0; idle(10);
        btn_step = 1;
        wait_state(2, "repress_burst");
        burst_len = 16'd2;
        idle(3); btn_step = 0; idle(20);
        chk("repress_en_cycles", en_cycles, 10);

        // Counter wrap.
        force dut.r_cycle_cnt = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        tick();
        release dut.r_cycle_cnt;
        btn_run = 1;
        wait_state(1, "wrap_run");
        idle(3);
        chk("wrap_cnt", cycle_cnt, 32'h0000_0001);
        btn_run = 0; btn_halt = 1; idle(10); btn_halt = 0; idle(8);

        // Random stimulus.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 23) == 0) btn_run = ~btn_run;
            if ($urandom_range(0, 19) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 39) == 0) btn_halt = ~btn_halt;
            if ($urandom_range(0, 15) == 0) burst_len = 16'($urandom_range(0, 6));
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000, consecutive stable cycles needed to accept a button level.
REQ-002 Parameter RUN_TIMEOUT, default 500000000, enabled cycles after which free-run auto-halts.
REQ-003 clock  input  1  system clock (50 MHz).
REQ-004 rst  input  1  synchronous, active-high reset; sampled on posedge clock.
REQ-005 btn_run  input  1  raw asynchronous pushbutton, request free-run.
REQ-006 btn_step  input  1  raw asynchronous pushbutton, request burst of burst_len cycles.
REQ-007 btn_halt  input  1  raw asynchronous pushbutton, request stop.
REQ-008 burst_len  input  16  enabled cycles per step command; sampled at acceptance.
REQ-009 cpu_clk_en  output  1  registered enable for the pipeline clock gate.
REQ-010 state  output  2  00 IDLE, 01 RUN, 10 BURST.
REQ-011 cycle_cnt  output  32  total enabled cycles since reset.
REQ-012 timeout_flag  output  1  sticky, set when RUN ended by RUN_TIMEOUT.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer that updates its level only after DEB_CYCLES consecutive equal synchronized samples.
REQ-014 A 0->1 transition of a debounced level SHALL produce a single-cycle command pulse; holding the button produces no further pulses.
REQ-015 Simultaneous pulses SHALL resolve halt > run > step; lower-priority pulses in that cycle are discarded.
REQ-016 IDLE: run pulse -> RUN; step pulse -> BURST, loading remaining = (burst_len==0 ? 1 : burst_len).
REQ-017 RUN: halt pulse -> IDLE; step pulse ignored; run pulse ignored (timeout counter not restarted).
REQ-018 RUN: timeout counter increments each enabled cycle; on reaching RUN_TIMEOUT the SHALL-transition is RUN -> IDLE with timeout_flag set in the same edge.
REQ-019 BURST: remaining decrements each enabled cycle; after the cycle with remaining==1, state -> IDLE.
REQ-020 BURST: halt pulse -> IDLE immediately, remaining cleared; run pulse -> RUN (burst abandoned); step pulse ignored.
REQ-021 cpu_clk_en SHALL be high exactly in cycles where state is RUN or BURST; a command pulse in cycle k yields state and cpu_clk_en change at edge k+1 (latency 1).
REQ-022 A step with burst_len=N SHALL yield exactly N cycles of cpu_clk_en high, contiguous.
REQ-023 cycle_cnt SHALL increment on every cycle cpu_clk_en is high, wrapping 0xFFFFFFFF -> 0.
REQ-024 Timeout counter SHALL clear on every entry into RUN.
REQ-025 timeout_flag SHALL clear when any run or step pulse is accepted.
REQ-026 burst_len changes while in BURST SHALL NOT affect the running burst.

Reset
REQ-027 rst SHALL force state IDLE, cpu_clk_en 0, cycle_cnt 0, timeout_flag 0, remaining 0, timeout counter 0, debouncer levels 0 and debounce counters 0, taking effect at the same edge, including mid-RUN or mid-BURST.
REQ-028 No command pulse SHALL be emitted during reset or in the first cycle after it, even if a button is held (held button requires release and re-press).

Structure
REQ-029 State encodings (IDLE, RUN, BURST) SHALL live in shared package clk_step_pkg for use by display/debug logic.
REQ-030 Synchronizer + debouncer + edge detector SHALL be one sub-module btn_debounce, instantiated three times, parameterized by DEB_CYCLES.
REQ-031 cpu_clk_en SHALL be the only gating control to the pipeline clock gate; no combinational path from buttons to cpu_clk_en.

Verification (DEB_CYCLES=4, RUN_TIMEOUT=20)
REQ-032 Press btn_step with burst_len=3 -> exactly 3 contiguous cpu_clk_en cycles, state 10 then 00, cycle_cnt=3.
REQ-033 btn_run bouncing 1-0-1 each 2 cycles then stable 10 cycles -> one run pulse only; cpu_clk_en high 20 cycles, then IDLE, timeout_flag=1, cycle_cnt=20.
REQ-034 In RUN, press btn_halt -> cpu_clk_en low at edge after pulse, state 00, timeout_flag=0.
REQ-035 run and halt pulses same cycle from IDLE -> stays IDLE, cpu_clk_en 0; step with burst_len=0 -> exactly 1 enabled cycle.
REQ-036 Assert rst mid-BURST (burst_len=10, after 4 cycles) -> next edge state 00, cpu_clk_en 0, cycle_cnt 0; held btn_step produces no burst until released and re-pressed.
REQ-037 Preload cycle_cnt path to 0xFFFFFFFE via forced run, 3 enabled cycles -> cycle_cnt wraps to 0x00000001.
